// File: rtl/sr_flop_bank.sv
`default_nettype none
// ============================================================================
// Module      : sr_flop_bank
// Description : Bank of WIDTH clocked SR storage cells with enable, a
//               configurable S=R=1 policy, rise/fall pulses and sticky
//               conflict flags. Optional conflict counter: SR_CONFLICT_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_flop_bank #(
    parameter int               WIDTH         = 8,
    parameter int               CONFLICT_MODE = 0,
    parameter logic [WIDTH-1:0] INIT          = '0,
    parameter int               CNT_W         = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    input  logic             Clr_err,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic [WIDTH-1:0] Rise,
    output logic [WIDTH-1:0] Fall,
    output logic [WIDTH-1:0] Err
`ifdef SR_CONFLICT_CNT_EN
    ,
    output logic [CNT_W-1:0] Conflict_cnt
`endif
);

    // Out-of-range policy codes fall back to hold.
    localparam int c_mode = (CONFLICT_MODE >= 0 && CONFLICT_MODE <= 3) ? CONFLICT_MODE : 0;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] err_q, err_d;
    logic [WIDTH-1:0] w_conflict;
    logic [WIDTH-1:0] w_conf_val;
    logic [WIDTH-1:0] w_next;

    generate
        if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
            $error("sr_flop_bank: WIDTH and CNT_W must be at least 1");
        end
    endgenerate

    assign w_conflict = S & R;

    always_comb begin
        case (c_mode)
            1:       w_conf_val = '0;
            2:       w_conf_val = '1;
            3:       w_conf_val = ~q_q;
            default: w_conf_val = q_q;
        endcase
    end

    assign w_next = (S & ~R) | (~S & ~R & q_q) | (w_conflict & w_conf_val);

    always_comb begin
        q_d    = q_q;
        rise_d = '0;
        fall_d = '0;
        err_d  = Clr_err ? '0 : err_q;
        if (En) begin
            q_d    = w_next;
            rise_d = w_next & ~q_q;
            fall_d = ~w_next & q_q;
            err_d  = err_d | w_conflict;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            q_q    <= INIT;
            rise_q <= '0;
            fall_q <= '0;
            err_q  <= '0;
        end else begin
            q_q    <= q_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            err_q  <= err_d;
        end
    end

    assign Q    = q_q;
    assign Qn   = ~q_q;
    assign Rise = rise_q;
    assign Fall = fall_q;
    assign Err  = err_q;

`ifdef SR_CONFLICT_CNT_EN
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_any_conflict;

    assign w_any_conflict = En & (|w_conflict);

    // A clear coinciding with a new conflict counts that conflict.
    always_comb begin
        cnt_d = cnt_q;
        if (Clr_err) begin
            cnt_d = w_any_conflict ? CNT_W'(1) : '0;
        end else if (w_any_conflict && cnt_q != c_cnt_max) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Conflict_cnt = cnt_q;
`endif

endmodule
`default_nettype wire
